// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a 4-slot time-division-multiplexed line.
// Samples arrive one per accepted cycle on din. Slot 0 is marked by frame_sync.
// Each sample is steered into its own per-channel holding register.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   din        - sample on the shared line (WIDTH bits)
//   din_valid  - din carries a sample this cycle (no backpressure)
//   frame_sync - current sample is slot 0 (ignored when din_valid=0)
//   dout       - channel registers, ch k at dout[k*WIDTH +: WIDTH]
//   ch_valid   - one-hot pulse, channel k register updated
//   frame_done - pulse, slot 3 of an aligned frame captured
//   locked     - frame alignment held
//   sync_err   - pulse on a framing violation
//   err_cnt    - saturating count of sync_err events
module tdm_demux4 #(
    parameter int WIDTH       = 8,
    parameter bit STRICT_SYNC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [4*WIDTH-1:0]   dout,
    output logic [3:0]           ch_valid,
    output logic                 frame_done,
    output logic                 locked,
    output logic                 sync_err,
    output logic [7:0]           err_cnt
);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          slot_r;
    logic [1:0]          slot_s;
    logic [4*WIDTH-1:0]  dout_r;
    logic [4*WIDTH-1:0]  dout_s;
    logic [3:0]          ch_valid_r;
    logic [3:0]          ch_valid_s;
    logic                frame_done_r;
    logic                frame_done_s;
    logic                sync_err_r;
    logic                sync_err_s;
    logic                locked_r;
    logic [7:0]          err_cnt_r;
    logic [7:0]          err_cnt_s;
    logic                wr_en_s;
    logic [1:0]          wr_slot_s;

    // Framing FSM: decides which slot (if any) is written and the next alignment.
    always_comb begin
        state_s      = state_r;
        slot_s       = slot_r;
        wr_en_s      = 1'b0;
        wr_slot_s    = 2'd0;
        frame_done_s = 1'b0;
        sync_err_s   = 1'b0;
        case (state_r)
            HUNT: begin
                if (din_valid && frame_sync) begin
                    wr_en_s   = 1'b1;
                    wr_slot_s = 2'd0;
                    slot_s    = 2'd1;
                    state_s   = LOCKED;
                end else begin
                    // Pre-lock samples are dropped silently.
                    state_s = HUNT;
                end
            end
            LOCKED: begin
                if (!din_valid) begin
                    state_s = LOCKED;
                end else if (slot_r != 2'd0) begin
                    if (frame_sync) begin
                        // Early sync: abandon the partial frame and realign on this sample.
                        sync_err_s = 1'b1;
                        wr_en_s    = 1'b1;
                        wr_slot_s  = 2'd0;
                        slot_s     = 2'd1;
                    end else begin
                        wr_en_s      = 1'b1;
                        wr_slot_s    = slot_r;
                        slot_s       = slot_r + 2'd1;
                        frame_done_s = (slot_r == 2'd3);
                    end
                end else begin
                    if (frame_sync || (STRICT_SYNC == 1'b0)) begin
                        wr_en_s   = 1'b1;
                        wr_slot_s = 2'd0;
                        slot_s    = 2'd1;
                    end else begin
                        // Missing sync at a frame boundary loses lock; sample discarded.
                        sync_err_s = 1'b1;
                        slot_s     = 2'd0;
                        state_s    = HUNT;
                    end
                end
            end
            default: begin
                state_s = HUNT;
                slot_s  = 2'd0;
            end
        endcase
    end

    // Datapath: channel write, one-hot strobe and saturating error count.
    always_comb begin
        dout_s = dout_r;
        for (int k = 0; k < 4; k++) begin
            if (wr_en_s && (wr_slot_s == 2'(k))) begin
                dout_s[k*WIDTH +: WIDTH] = din;
            end else begin
                dout_s[k*WIDTH +: WIDTH] = dout_r[k*WIDTH +: WIDTH];
            end
        end
        if (wr_en_s) begin
            ch_valid_s = 4'b0001 << wr_slot_s;
        end else begin
            ch_valid_s = 4'b0000;
        end
        if (sync_err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_s = err_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= HUNT;
            slot_r       <= 2'd0;
            dout_r       <= '0;
            ch_valid_r   <= 4'b0000;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            locked_r     <= 1'b0;
            err_cnt_r    <= 8'd0;
        end else begin
            state_r      <= state_s;
            slot_r       <= slot_s;
            dout_r       <= dout_s;
            ch_valid_r   <= ch_valid_s;
            frame_done_r <= frame_done_s;
            sync_err_r   <= sync_err_s;
            locked_r     <= (state_s == LOCKED);
            err_cnt_r    <= err_cnt_s;
        end
    end

    assign dout       = dout_r;
    assign ch_valid   = ch_valid_r;
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;
    assign locked     = locked_r;
    assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4. A strict-sync and a loose-sync instance share stimulus.
// Expected strobe events of the strict instance are queued by the driver and
// popped by a monitor whenever the DUT raises a strobe.
module tb_tdm_demux4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        frame_sync;

    logic [31:0] s_dout;
    logic [3:0]  s_ch_valid;
    logic        s_frame_done;
    logic        s_locked;
    logic        s_sync_err;
    logic [7:0]  s_err_cnt;

    logic [31:0] l_dout;
    logic [3:0]  l_ch_valid;
    logic        l_frame_done;
    logic        l_locked;
    logic        l_sync_err;
    logic [7:0]  l_err_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  cv;
        logic        fd;
        logic        se;
        logic        lk;
        logic [31:0] dout;
        logic [7:0]  ec;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  exp_ch[4];
    logic [7:0]  exp_ec;

    tdm_demux4 #(.WIDTH(8), .STRICT_SYNC(1'b1)) u_strict (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .dout(s_dout), .ch_valid(s_ch_valid),
        .frame_done(s_frame_done), .locked(s_locked), .sync_err(s_sync_err),
        .err_cnt(s_err_cnt)
    );

    tdm_demux4 #(.WIDTH(8), .STRICT_SYNC(1'b0)) u_loose (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .dout(l_dout), .ch_valid(l_ch_valid),
        .frame_done(l_frame_done), .locked(l_locked), .sync_err(l_sync_err),
        .err_cnt(l_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one accepted sample with its hand-computed strict-instance response.
    task automatic send(input logic sy, input logic [7:0] d, input logic [3:0] cv,
                        input logic fd, input logic se, input logic lk);
        exp_t e;
        @(negedge clk);
        frame_sync = sy;
        din        = d;
        din_valid  = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (cv[k]) exp_ch[k] = d;
        end
        if (se && (exp_ec != 8'd255)) exp_ec = exp_ec + 8'd1;
        if ((cv != 4'b0000) || fd || se) begin
            e.cv   = cv;
            e.fd   = fd;
            e.se   = se;
            e.lk   = lk;
            e.dout = {exp_ch[3], exp_ch[2], exp_ch[1], exp_ch[0]};
            e.ec   = exp_ec;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid  = 1'b0;
            frame_sync = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        q.delete();
        for (int k = 0; k < 4; k++) exp_ch[k] = 8'h00;
        exp_ec = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every strobe from the strict instance must match the next queued event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if ((s_ch_valid != 4'b0000) || s_frame_done || s_sync_err) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe actual ch_valid=%b frame_done=%b sync_err=%b required none",
                             s_ch_valid, s_frame_done, s_sync_err);
                end else begin
                    e = q.pop_front();
                    chk("ev_ch_valid",   {28'd0, s_ch_valid},   {28'd0, e.cv});
                    chk("ev_frame_done", {31'd0, s_frame_done}, {31'd0, e.fd});
                    chk("ev_sync_err",   {31'd0, s_sync_err},   {31'd0, e.se});
                    chk("ev_locked",     {31'd0, s_locked},     {31'd0, e.lk});
                    chk("ev_dout",       s_dout,                e.dout);
                    chk("ev_err_cnt",    {24'd0, s_err_cnt},    {24'd0, e.ec});
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        for (int k = 0; k < 4; k++) exp_ch[k] = 8'h00;
        exp_ec = 8'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_dout",       s_dout,                 32'h0);
        chk("rst_ch_valid",   {28'd0, s_ch_valid},    32'h0);
        chk("rst_frame_done", {31'd0, s_frame_done},  32'h0);
        chk("rst_locked",     {31'd0, s_locked},      32'h0);
        chk("rst_sync_err",   {31'd0, s_sync_err},    32'h0);
        chk("rst_err_cnt",    {24'd0, s_err_cnt},     32'h0);
        chk("rst_loose_dout", l_dout,                 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Acquire and a back-to-back frame.
        send(1'b1, 8'h11, 4'b0001, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h22, 4'b0010, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h33, 4'b0100, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h44, 4'b1000, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("frame1_dout", s_dout, 32'h44332211);

        // Pre-lock garbage then a gapped frame.
        do_reset();
        send(1'b0, 8'hAA, 4'b0000, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'hBB, 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("garbage_dout",   s_dout,             32'h0);
        chk("garbage_locked", {31'd0, s_locked},  32'h0);
        send(1'b1, 8'h11, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(2);
        send(1'b0, 8'h22, 4'b0010, 1'b0, 1'b0, 1'b1);
        idle(2);
        send(1'b0, 8'h33, 4'b0100, 1'b0, 1'b0, 1'b1);
        idle(2);
        send(1'b0, 8'h44, 4'b1000, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("gapped_dout", s_dout, 32'h44332211);

        // Early sync realigns mid-frame.
        send(1'b1, 8'h01, 4'b0001, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h02, 4'b0010, 1'b0, 1'b0, 1'b1);
        send(1'b1, 8'h05, 4'b0001, 1'b0, 1'b1, 1'b1);
        send(1'b0, 8'h06, 4'b0010, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h07, 4'b0100, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h08, 4'b1000, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("early_dout",    s_dout,              32'h08070605);
        chk("early_err_cnt", {24'd0, s_err_cnt},  32'd1);

        // Missing sync at slot 0: strict drops lock, loose keeps writing.
        send(1'b0, 8'h99, 4'b0000, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("miss_strict_locked", {31'd0, s_locked},  32'h0);
        chk("miss_strict_ch0",    {24'd0, s_dout[7:0]}, 32'h05);
        chk("miss_strict_errcnt", {24'd0, s_err_cnt}, 32'd2);
        chk("miss_loose_locked",  {31'd0, l_locked},  32'h1);
        chk("miss_loose_ch0",     {24'd0, l_dout[7:0]}, 32'h99);
        chk("miss_loose_errcnt",  {24'd0, l_err_cnt}, 32'd1);
        send(1'b1, 8'h10, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("relock_locked", {31'd0, s_locked}, 32'h1);
        chk("relock_dout",   s_dout,            32'h08070610);

        // Error counter saturation, then asynchronous reset mid-frame.
        do_reset();
        send(1'b1, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) begin
            send(1'b1, 8'(i), 4'b0001, 1'b0, 1'b1, 1'b1);
        end
        send(1'b0, 8'h77, 4'b0010, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        chk("sat_err_cnt", {24'd0, s_err_cnt}, 32'd255);
        rst_n = 1'b0;
        #1;
        chk("async_dout",     s_dout,                32'h0);
        chk("async_ch_valid", {28'd0, s_ch_valid},   32'h0);
        chk("async_locked",   {31'd0, s_locked},     32'h0);
        chk("async_err_cnt",  {24'd0, s_err_cnt},    32'h0);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the 4:1 selector datapath.
- Takes a single time-division-multiplexed sample stream (slot 0..3, slot 0 marked by frame_sync) and steers each sample to its own per-channel holding register.
- Per-channel and per-frame strobes go to downstream logic.
- Sits at the far end of the shared line that the 4:1 mux drives.

Parameters:
- WIDTH, 8, bit width of one sample and of each channel register.
- STRICT_SYNC, 1, 1 = frame_sync required on every slot-0 sample; 0 = frame_sync only needed to acquire lock.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  sample on the shared line.
- din_valid  input  1  din carries a sample this cycle; no backpressure.
- frame_sync  input  1  qualifies the current sample as slot 0; ignored when din_valid=0.
- dout  output  4*WIDTH  channel registers; ch k at dout[k*WIDTH +: WIDTH].
- ch_valid  output  4  one-hot, 1-cycle pulse: channel k register updated.
- frame_done  output  1  1-cycle pulse: slot 3 of an aligned frame captured.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  1-cycle pulse on framing violation.
- err_cnt  output  8  saturating count of sync_err events.

Behaviour:
- Reset (rst_n=0, async): state=HUNT, slot=0, dout=0, ch_valid=0, frame_done=0, locked=0, sync_err=0, err_cnt=0. All outputs are registered.
- Accept = din_valid=1 at a rising edge. Cycles with din_valid=0 change nothing except clearing the pulse outputs (ch_valid, frame_done, sync_err).
- Latency: a sample accepted at edge N is visible on dout, with its ch_valid bit, after edge N. At most one ch_valid bit is high per cycle.
- Slot decode: the write enable for channel k is the one-hot of slot (1<<slot), gated by accept.
- HUNT:
  - accept & frame_sync -> dout ch0<=din, ch_valid=0001, slot<=1, state<=LOCKED.
  - accept & !frame_sync -> sample discarded, no strobe, no error.
- LOCKED, on accept:
  - slot!=0 & !frame_sync -> ch[slot]<=din, ch_valid bit slot set, slot<=slot+1. If slot=3: slot wraps to 0 and frame_done=1.
  - slot!=0 & frame_sync (early sync) -> sync_err=1, err_cnt+1. Realign: ch0<=din, ch_valid=0001, slot<=1. Partial frame abandoned, no frame_done. Stay LOCKED.
  - slot=0 & frame_sync -> normal ch0 write, slot<=1.
  - slot=0 & !frame_sync, STRICT_SYNC=1 -> sync_err=1, err_cnt+1, sample discarded, state<=HUNT, slot<=0.
  - slot=0 & !frame_sync, STRICT_SYNC=0 -> treated as ch0 write, slot<=1.
- dout channel registers hold their value until rewritten, including across HUNT/LOCKED transitions. Only reset clears them.
- err_cnt saturates at 255 and does not wrap.
- locked = (state==LOCKED), registered.
- Reset asserted mid-frame: immediate return to reset values; the next frame must re-acquire via frame_sync.

Test Plan:
- Reset then acquire: rst_n low 3 cycles, release. Send {sync,0x11},{0x22},{0x33},{0x44} back-to-back -> locked=1 after first edge; ch_valid 0001,0010,0100,1000 on consecutive cycles; dout=0x44332211; frame_done pulses once, in the same cycle as ch_valid=1000.
- Pre-lock garbage plus gaps: 0xAA,0xBB without sync -> no strobes, dout=0. Then a frame with din_valid low for 2 cycles between every sample -> same results as above, strobes only on accept cycles.
- Early sync: frame 0x01,0x02 then {sync,0x05},0x06,0x07,0x08 -> sync_err pulse on the 0x05 capture, err_cnt=1; frame_done once, for the second frame only; dout=0x08070605.
- Missing sync, STRICT_SYNC=1: after a good frame, send 0x99 without sync -> sync_err, locked=0, ch0 unchanged. A following {sync,0x10} relocks.
- Same missing-sync stimulus with STRICT_SYNC=0 -> no error, ch0=0x99, locked stays 1.
- Saturation and async reset: force 260 early-sync errors -> err_cnt=255. Assert rst_n mid-frame between clock edges -> outputs zero immediately without waiting for a clk edge.
